keypad_scan: RTL

Matrix-keypad front end for the coded-lock datapath. It scans a 4x4 active-low keypad, synchronizes and debounces the row returns, and emits exactly one single-cycle event per physical key press: a digit on `din` with `key_valid`, or a `cancel` ('*') or `confirm` ('#') strobe. It sits between the keypad pins and the lock controller, and supplies that controller's `din`/`cancel`/`confirm` inputs.

---
 rtl/keypad_scan.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner.
// Drives one column low at a time, synchronizes and debounces the row returns,
// and emits one single-cycle event per physical key press: a digit on din with
// key_valid, or a cancel ('*') / confirm ('#') strobe. Keys A-D are debounced
// but produce no output.
module keypad_scan #(
   parameter int unsigned SCAN_CYCLES     = 4,  // dwell cycles per column, >= 3
   parameter int unsigned DEBOUNCE_CYCLES = 8   // stable samples for press/release, >= 1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] din,
   output logic       key_valid,
   output logic       cancel,
   output logic       confirm
);

   localparam int unsigned DwellW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
   localparam logic [CntW-1:0]   CntDone   = CntW'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StEmit,
      StHold
   } state_e;

   // Synchronizer stages
   logic [3:0]        row_sync_q;
   logic [3:0]        rs_q;

   // FSM state and datapath registers
   state_e            state_q;
   logic [1:0]        col_idx_q;
   logic [1:0]        row_idx_q;
   logic [3:0]        pat_q;
   logic [DwellW-1:0] dwell_q;
   logic [CntW-1:0]   cnt_q;

   // Registered outputs
   logic [3:0]        col_out_q;
   logic [3:0]        din_q;
   logic              key_valid_q;
   logic              cancel_q;
   logic              confirm_q;

   // Combinational helpers
   logic [3:0]        row_low;
   logic              one_low;
   logic [1:0]        row_enc;
   logic [1:0]        col_next;
   logic [CntW-1:0]   cnt_next;
   logic              cnt_hit;
   logic              key_digit;
   logic [3:0]        key_code;
   logic              key_cancel;
   logic              key_confirm;

   // Active-low column drive for a given column index
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   // Two-flop synchronizer for the asynchronous row returns; idles released (high)
   always_ff @(posedge clk) begin
      if (clr) begin
         row_sync_q <= 4'hF;
         rs_q       <= 4'hF;
      end else begin
         row_sync_q <= row_in;
         rs_q       <= row_sync_q;
      end
   end

   // Row pattern classification: exactly one row low, and which one
   always_comb begin
      row_low = ~rs_q;
      one_low = (row_low != 4'h0) && ((row_low & (row_low - 4'd1)) == 4'h0);
      row_enc = 2'd0;
      case (row_low)
         4'b0001: row_enc = 2'd0;
         4'b0010: row_enc = 2'd1;
         4'b0100: row_enc = 2'd2;
         4'b1000: row_enc = 2'd3;
         default: row_enc = 2'd0;
      endcase
   end

   // Counter stepping and column advance
   always_comb begin
      col_next = col_idx_q + 2'd1;
      cnt_next = cnt_q + CntW'(1);
      cnt_hit  = (cnt_next == CntDone);
   end

   // Key map decode of the latched [row][col] position
   always_comb begin
      key_digit   = 1'b0;
      key_code    = 4'd0;
      key_cancel  = 1'b0;
      key_confirm = 1'b0;
      if (row_idx_q != 2'd3) begin
         // Rows 0..2 carry 1..9 in columns 0..2; column 3 is A..C
         key_digit = (col_idx_q != 2'd3);
         key_code  = ({2'b00, row_idx_q} * 4'd3) + {2'b00, col_idx_q} + 4'd1;
      end else begin
         case (col_idx_q)
            2'd0:    key_cancel  = 1'b1;
            2'd1:    key_digit   = 1'b1;
            2'd2:    key_confirm = 1'b1;
            default: key_digit   = 1'b0;
         endcase
      end
   end

   // Scan / debounce / emit / hold FSM with registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= StScan;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         pat_q       <= 4'hF;
         dwell_q     <= '0;
         cnt_q       <= '0;
         col_out_q   <= 4'b1110;
         din_q       <= 4'd0;
         key_valid_q <= 1'b0;
         cancel_q    <= 1'b0;
         confirm_q   <= 1'b0;
      end else begin
         // Strobes are single-cycle unless EMIT raises one below
         key_valid_q <= 1'b0;
         cancel_q    <= 1'b0;
         confirm_q   <= 1'b0;

         case (state_q)
            StScan: begin
               if (dwell_q == DwellLast) begin
                  dwell_q <= '0;
                  if (one_low) begin
                     row_idx_q <= row_enc;
                     pat_q     <= rs_q;
                     cnt_q     <= CntW'(1);
                     // The sample itself is the first stable one; with a single
                     // required sample the press is already confirmed.
                     state_q   <= (DEBOUNCE_CYCLES <= 1) ? StEmit : StDebounce;
                  end else begin
                     // Idle column, or a ghost/multi-key pattern: move on
                     col_idx_q <= col_next;
                     col_out_q <= col_drive(col_next);
                  end
               end else begin
                  dwell_q <= dwell_q + DwellW'(1);
               end
            end

            StDebounce: begin
               if (rs_q == pat_q) begin
                  if (cnt_hit) begin
                     cnt_q   <= '0;
                     state_q <= StEmit;
                  end else begin
                     cnt_q <= cnt_next;
                  end
               end else begin
                  // Bounce: drop the candidate and resume scanning
                  cnt_q     <= '0;
                  dwell_q   <= '0;
                  col_idx_q <= col_next;
                  col_out_q <= col_drive(col_next);
                  state_q   <= StScan;
               end
            end

            StEmit: begin
               if (key_digit) begin
                  din_q       <= key_code;
                  key_valid_q <= 1'b1;
               end
               cancel_q  <= key_cancel;
               confirm_q <= key_confirm;
               cnt_q     <= '0;
               state_q   <= StHold;
            end

            StHold: begin
               // Wait for a stable all-released pattern; other columns stay masked
               if (rs_q != 4'hF) begin
                  cnt_q <= '0;
               end else if (cnt_hit) begin
                  cnt_q     <= '0;
                  dwell_q   <= '0;
                  col_idx_q <= col_next;
                  col_out_q <= col_drive(col_next);
                  state_q   <= StScan;
               end else begin
                  cnt_q <= cnt_next;
               end
            end

            default: begin
               state_q <= StScan;
            end
         endcase
      end
   end

   assign col_out   = col_out_q;
   assign din       = din_q;
   assign key_valid = key_valid_q;
   assign cancel    = cancel_q;
   assign confirm   = confirm_q;

endmodule
